// File: rtl/cpu_trace_buffer_if.sv
// Commit-side and readout-side bus of the CPU trace buffer.
// master: CPU commit source plus debug host; slave: the trace buffer itself.
interface cpu_trace_buffer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int RF_AW   = 5,
    parameter int TS_W    = 16
);
    // Commit port, fed from PC, instruction memory and regfile write port
    logic               cm_valid;
    logic [ADDR_W-1:0]  cm_pc;
    logic [INSTR_W-1:0] cm_instr;
    logic               cm_we;
    logic [RF_AW-1:0]   cm_waddr;
    logic [DATA_W-1:0]  cm_wdata;

    // Readout port, drained by the debug host
    logic               rd_valid;
    logic               rd_ready;
    logic [ADDR_W-1:0]  rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic               rd_we;
    logic [RF_AW-1:0]   rd_waddr;
    logic [DATA_W-1:0]  rd_wdata;
    logic [TS_W-1:0]    rd_ts;

    modport master (
        output cm_valid, cm_pc, cm_instr, cm_we, cm_waddr, cm_wdata,
        output rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_we, rd_waddr, rd_wdata, rd_ts
    );

    modport slave (
        input  cm_valid, cm_pc, cm_instr, cm_we, cm_waddr, cm_wdata,
        input  rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_we, rd_waddr, rd_wdata, rd_ts
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture unit for the MIPS core.
// Records retired instructions {pc, instr, we, waddr, wdata, ts} into a
// DEPTH-entry buffer with optional PC trigger, ring / stop-when-full modes,
// and drains oldest-first through a valid/ready readout port.
// Optional feature macro: TRACE_FILTER_EN -- record only commits that write
// a non-zero register.
module cpu_trace_buffer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int RF_AW   = 5,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     mode,
    input  logic                     trig_en,
    input  logic [ADDR_W-1:0]        trig_pc,
    cpu_trace_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state_o,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               we;
        logic [RF_AW-1:0]   waddr;
        logic [DATA_W-1:0]  wdata;
        logic [TS_W-1:0]    ts;
    } entry_t;

    entry_t          mem [DEPTH];
    state_t          state_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [TS_W-1:0] ts_q;
    logic            overflow_q;

    logic rec;
    logic trig_hit;
    logic full;
    logic pop;
    logic wr_en;
    logic rd_valid;

    // Decode this cycle's commit: recordable, trigger match, and whether it lands in memory
    always_comb begin
        rec      = 1'b0;
        trig_hit = 1'b0;
        full     = 1'b0;
        pop      = 1'b0;
        wr_en    = 1'b0;
        rd_valid = 1'b0;
`ifdef TRACE_FILTER_EN
        rec      = bus.cm_valid && bus.cm_we && (bus.cm_waddr != '0);
`else
        rec      = bus.cm_valid;
`endif
        trig_hit = bus.cm_valid && (bus.cm_pc == trig_pc);
        full     = (count_q == FULL_CNT);
        rd_valid = (state_q == DONE) && (count_q != '0);
        pop      = rd_valid && bus.rd_ready;
        // A full buffer in stop-when-full mode drops the commit instead of writing it
        wr_en    = !arm && rec &&
                   (((state_q == CAPTURE) && !(full && !mode)) ||
                    ((state_q == ARMED) && trig_hit));
    end

    // Trace memory: written on record, no reset (contents are don't-care)
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_ptr_q] <= '{pc:    bus.cm_pc,
                               instr: bus.cm_instr,
                               we:    bus.cm_we,
                               waddr: bus.cm_waddr,
                               wdata: bus.cm_wdata,
                               ts:    ts_q};
        end
    end

    // Session FSM with pointers, occupancy, timestamp and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else if (arm) begin
            state_q    <= trig_en ? ARMED : CAPTURE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ARMED: begin
                    ts_q <= ts_q + 1'b1;
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        count_q  <= count_q + 1'b1;
                    end
                    if (stop) begin
                        state_q <= DONE;
                    end else if (trig_hit) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    ts_q <= ts_q + 1'b1;
                    if (rec) begin
                        if (full) begin
                            // Ring mode overwrites the oldest; otherwise the commit is dropped
                            if (mode) begin
                                wr_ptr_q <= wr_ptr_q + 1'b1;
                                rd_ptr_q <= rd_ptr_q + 1'b1;
                            end
                            overflow_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            count_q  <= count_q + 1'b1;
                            if (!mode && (count_q == LAST_CNT)) begin
                                state_q <= DONE;
                            end
                        end
                    end
                    if (stop) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        count_q  <= count_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_pc    = mem[rd_ptr_q].pc;
    assign bus.rd_instr = mem[rd_ptr_q].instr;
    assign bus.rd_we    = mem[rd_ptr_q].we;
    assign bus.rd_waddr = mem[rd_ptr_q].waddr;
    assign bus.rd_wdata = mem[rd_ptr_q].wdata;
    assign bus.rd_ts    = mem[rd_ptr_q].ts;

    assign count    = count_q;
    assign state_o  = state_q;
    assign overflow = overflow_q;

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable commit-trace capture unit for the 31/54-instruction MIPS core. It replaces per-cycle simulation dumps of PC, instruction and register writes.
- Records retired-instruction records into a parametrised on-chip buffer. Supports optional PC trigger, ring or stop-when-full mode, and a stamp for every record.
- Sits beside the CPU top, fed from the PC, instruction memory output and regfile write port. Drained by a debug host through a valid/ready port.

Parameters:
- ADDR_W, 32, PC width.
- INSTR_W, 32, instruction width.
- DATA_W, 32, regfile write-data width.
- RF_AW, 5, regfile address width (32 registers).
- DEPTH, 16, number of trace entries; power of 2, at least 2.
- TS_W, 16, timestamp width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- arm  in  1  1-cycle pulse; clears buffer and starts a session.
- stop  in  1  1-cycle pulse; ends capture.
- mode  in  1  0 = stop when full, 1 = ring (overwrite oldest).
- trig_en  in  1  wait for trig_pc before capturing.
- trig_pc  in  ADDR_W  trigger PC.
- cm_valid  in  1  an instruction retires this cycle.
- cm_pc  in  ADDR_W  PC of the retiring instruction.
- cm_instr  in  INSTR_W  retiring instruction word.
- cm_we  in  1  regfile write enable.
- cm_waddr  in  RF_AW  regfile write address.
- cm_wdata  in  DATA_W  regfile write data.
- rd_valid  out  1  entry available at the head.
- rd_ready  in  1  host accepts the head entry.
- rd_pc, rd_instr, rd_we, rd_waddr, rd_wdata, rd_ts  out  (matching widths)  head entry fields.
- count  out  $clog2(DEPTH)+1  entries held.
- state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- overflow  out  1  sticky: an entry was overwritten or dropped.

Behaviour:
- Reset (rst==0 at posedge):
  - state IDLE; wr_ptr, rd_ptr, count, ts all 0; overflow 0; rd_valid 0.
  - Memory contents are don't-care.
- arm has priority over every other event, in any state:
  - Clears pointers, count, ts and overflow.
  - Next state is ARMED if trig_en, else CAPTURE.
  - A commit in the same cycle as arm is not recorded.
- stop:
  - In ARMED or CAPTURE, goes to DONE. A commit in the same cycle as stop is recorded.
  - In IDLE or DONE, stop is ignored.
- ts:
  - Counts +1 every cycle in ARMED and CAPTURE; wraps modulo 2^TS_W.
  - Frozen in IDLE and DONE.
  - A stored entry carries the ts value of its commit cycle.
- ARMED:
  - When cm_valid && cm_pc==trig_pc, that commit is recorded and state goes to CAPTURE.
  - Other commits are ignored.
- CAPTURE: each cm_valid writes {pc, instr, we, waddr, wdata, ts} at wr_ptr on the posedge, then wr_ptr advances. Handling at full (count==DEPTH):
  - mode 0: the write that makes count==DEPTH moves state to DONE in the same edge. A later commit cannot occur in CAPTURE.
  - mode 1: when full, the new commit overwrites the oldest entry; rd_ptr advances, count stays DEPTH, overflow is set.
- Pointers wrap modulo DEPTH.
- Readout:
  - rd_valid = (state==DONE) && (count!=0).
  - rd_* fields are combinational from mem[rd_ptr].
  - Pop on rd_valid && rd_ready: rd_ptr+1, count-1.
  - Zero-latency head update: the next entry is visible in the cycle after the pop.
- DONE holds until arm. Once the buffer drains, rd_valid=0 and state stays DONE.
- Entries always read out oldest-first.
- mode, trig_en and trig_pc are sampled every cycle. The host must hold them stable while ARMED or CAPTURE.

Optional Feature:
- TRACE_FILTER_EN defined:
  - A commit is recordable only if cm_we==1 && cm_waddr!=0. This applies to the trigger commit too: a trigger PC match without a write arms CAPTURE but is not stored.
  - In mode 0, non-writing commits never count toward full.
- Undefined: every cm_valid commit is recordable.

Test Plan:
- Continuous capture: DEPTH=4, mode=0, trig_en=0, arm. Feed commits PC 0x00400000, 0x00400004, 0x00400008, 0x0040000C with one idle cycle between the 2nd and 3rd. Required:
  - state=DONE on the 4th write edge; count=4.
  - rd_ts = 0, 1, 3, 4.
  - Drain with rd_ready=1 yields the PCs in order; then rd_valid=0.
- Ring overflow: DEPTH=4, mode=1, arm. Feed 6 commits with PC 0x0, 0x4, …, 0x14, then stop. Required:
  - count=4, overflow=1.
  - Drain yields 0x8, 0xC, 0x10, 0x14.
- Trigger: trig_en=1, trig_pc=0x00400010, arm. Feed PCs 0x00400000 through 0x00400018 step 4, then stop. Required:
  - state stays ARMED until the 0x00400010 commit.
  - Entries are exactly 0x00400010, 0x00400014, 0x00400018.
- Priority and collisions:
  - arm and stop in the same cycle → CAPTURE with count=0.
  - Commit in the arm cycle → not stored.
  - stop with a commit in the same cycle → that commit is stored, state=DONE.
- Reset mid-session: in CAPTURE with count=3, assert rst=0 for one edge. Required: state=IDLE, count=0, overflow=0, rd_valid=0.
- Filter (TRACE_FILTER_EN): feed commits that are in order: we=1 waddr=0, we=0, we=1 waddr=8 wdata=0xDEADBEEF, then stop. Required: count=1; rd_waddr=8, rd_wdata=0xDEADBEEF.
